// File: rtl/tone_detector_pkg.sv
// -----------------------------------------------------------------------------
// tone_detector_pkg
//   Constants and types shared by the GPIO square-wave audio path.
//   - CLK_HZ, TONE_A4_HALF, TONE_A5_HALF : system clock and tone half-periods,
//     common with the tone generator.
//   - det_state_e  : detector FSM state encoding.
//   - tone_flags_t : the four mutually exclusive status flags, packed in LED
//     order {silent, other, a5, a4}.
// -----------------------------------------------------------------------------
package tone_detector_pkg;

   localparam int unsigned CLK_HZ       = 25_000_000;
   localparam int unsigned TONE_A4_HALF = CLK_HZ / 440 / 2;   // 28409 cycles
   localparam int unsigned TONE_A5_HALF = CLK_HZ / 880 / 2;   // 14204 cycles

   typedef enum logic {
      ST_SILENT  = 1'b0,
      ST_MEASURE = 1'b1
   } det_state_e;

   typedef struct packed {
      logic silent;
      logic other;
      logic a5;
      logic a4;
   } tone_flags_t;

   localparam tone_flags_t FLAGS_SILENT = '{silent: 1'b1, other: 1'b0, a5: 1'b0, a4: 1'b0};
   localparam tone_flags_t FLAGS_NONE   = '{silent: 1'b0, other: 1'b0, a5: 1'b0, a4: 1'b0};

endpackage

// File: rtl/tone_detector_level_filter.sv
// -----------------------------------------------------------------------------
// level_filter
//   Brings an asynchronous pin into the clock domain and removes glitches.
//   A 2-flop synchronizer feeds a stable-count that runs while the synced value
//   differs from the filtered level and clears whenever they agree. After
//   GLITCH_CYCLES consecutive differing cycles the filtered level flips and
//   edge_o pulses for one cycle (either polarity). Pin-to-edge latency is
//   2 + GLITCH_CYCLES cycles.
// Ports
//   clk     in  1  system clock
//   rst_n   in  1  asynchronous active-low reset
//   din_i   in  1  asynchronous input pin
//   edge_o  out 1  one-cycle pulse on each accepted level change
// -----------------------------------------------------------------------------
module level_filter #(
   parameter int unsigned GLITCH_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din_i,
   output logic edge_o
);

   localparam int unsigned STB_W = $clog2(GLITCH_CYCLES + 1);
   localparam logic [STB_W-1:0] STB_LAST = STB_W'(GLITCH_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q;
   logic             edge_q;
   logic [STB_W-1:0] stable_q;

   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // two synchronizer stages into one.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         level_q  <= 1'b0;
         edge_q   <= 1'b0;
         stable_q <= '0;
      end else begin
         sync1_q <= din_i;
         sync2_q <= sync1_q;
         edge_q  <= 1'b0;
         if (sync2_q == level_q) begin
            stable_q <= '0;
         end else if (stable_q == STB_LAST) begin
            // This cycle is the GLITCH_CYCLES-th consecutive disagreement.
            level_q  <= ~level_q;
            edge_q   <= 1'b1;
            stable_q <= '0;
         end else begin
            stable_q <= stable_q + 1'b1;
         end
      end
   end

   assign edge_o = edge_q;

endmodule

// File: rtl/tone_detector.sv
// -----------------------------------------------------------------------------
// tone_detector
//   Receive side of the GPIO square-wave audio path. Measures the half-period
//   of audio_in in clk_25mhz cycles, averages 2^AVG_LOG2 consecutive
//   half-periods in non-overlapping windows and classifies the mean as A4, A5,
//   other or silence.
// Ports
//   clk_25mhz        in  1      system clock
//   resetn           in  1      asynchronous active-low reset
//   audio_in         in  1      asynchronous square-wave input
//   half_period      out CNT_W  last measured half-period
//   sample_valid     out 1      pulse: half_period updated
//   half_period_avg  out CNT_W  mean of the last 2^AVG_LOG2 samples
//   avg_valid        out 1      pulse: half_period_avg and tone flags updated
//   tone_a4/a5/other out 1      classification of the latest average
//   silent           out 1      no edge for TIMEOUT_CYCLES, or since reset
//   led              out 4      {silent, tone_other, tone_a5, tone_a4}
// -----------------------------------------------------------------------------
module tone_detector #(
   parameter int unsigned CNT_W          = 20,
   parameter int unsigned TONE_A4_HALF   = tone_detector_pkg::TONE_A4_HALF,
   parameter int unsigned TONE_A5_HALF   = tone_detector_pkg::TONE_A5_HALF,
   parameter int unsigned TOL            = 256,
   parameter int unsigned AVG_LOG2       = 3,
   parameter int unsigned GLITCH_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 250000
) (
   input  logic             clk_25mhz,
   input  logic             resetn,
   input  logic             audio_in,
   output logic [CNT_W-1:0] half_period,
   output logic             sample_valid,
   output logic [CNT_W-1:0] half_period_avg,
   output logic             avg_valid,
   output logic             tone_a4,
   output logic             tone_a5,
   output logic             tone_other,
   output logic             silent,
   output logic [3:0]       led
);

   import tone_detector_pkg::*;

   localparam int unsigned ACC_W = CNT_W + AVG_LOG2;
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] A4_C      = CNT_W'(TONE_A4_HALF);
   localparam logic [CNT_W-1:0] A5_C      = CNT_W'(TONE_A5_HALF);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);

   logic                filt_edge;
   det_state_e          state_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [AVG_LOG2-1:0] nsamp_q;
   logic                avg_pend_q;
   logic [CNT_W-1:0]    half_period_q;
   logic [CNT_W-1:0]    avg_q;
   logic                sample_valid_q;
   logic                avg_valid_q;
   tone_flags_t         flags_q;
   logic [CNT_W-1:0]    avg_new;
   logic                meas_edge;
   logic                timeout_hit;

   level_filter #(
      .GLITCH_CYCLES (GLITCH_CYCLES)
   ) u_level_filter (
      .clk    (clk_25mhz),
      .rst_n  (resetn),
      .din_i  (audio_in),
      .edge_o (filt_edge)
   );

   function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
      return (a > b) ? (a - b) : (b - a);
   endfunction

   // A4 is tested first, so it wins if the tolerance windows ever overlap.
   function automatic tone_flags_t classify(input logic [CNT_W-1:0] avg);
      tone_flags_t f;
      f = FLAGS_NONE;
      if (abs_diff(avg, A4_C) <= TOL_C) begin
         f.a4 = 1'b1;
      end else if (abs_diff(avg, A5_C) <= TOL_C) begin
         f.a5 = 1'b1;
      end else begin
         f.other = 1'b1;
      end
      return f;
   endfunction

   assign meas_edge   = (state_q == ST_MEASURE) && filt_edge;
   // An edge on the timeout cycle is a valid (long) sample, so it wins.
   assign timeout_hit = (state_q == ST_MEASURE) && !filt_edge && (cnt_q == TIMEOUT_C);
   assign avg_new     = acc_q[ACC_W-1:AVG_LOG2];

   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d = cnt_q;
      if (filt_edge) begin
         cnt_d = CNT_W'(1);
      end else if (state_q == ST_SILENT) begin
         cnt_d = '0;
      end else if (cnt_q != CNT_MAX) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // The window sum is read one cycle after its last sample, then restarts;
   // a sample landing in that same cycle starts the next window.
   always_comb begin
      acc_d = avg_pend_q ? '0 : acc_q;
      if (meas_edge) begin
         acc_d = acc_d + ACC_W'(cnt_q);
      end else if (timeout_hit) begin
         acc_d = '0;
      end
   end

   always_ff @(posedge clk_25mhz or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   always_ff @(posedge clk_25mhz or negedge resetn) begin
      if (!resetn) begin
         state_q        <= ST_SILENT;
         nsamp_q        <= '0;
         avg_pend_q     <= 1'b0;
         half_period_q  <= '0;
         avg_q          <= '0;
         sample_valid_q <= 1'b0;
         avg_valid_q    <= 1'b0;
         flags_q        <= FLAGS_SILENT;
      end else begin
         sample_valid_q <= 1'b0;
         avg_valid_q    <= 1'b0;
         avg_pend_q     <= 1'b0;

         if (avg_pend_q) begin
            avg_q       <= avg_new;
            avg_valid_q <= 1'b1;
            flags_q     <= classify(avg_new);
         end

         unique case (state_q)
            ST_SILENT: begin
               // The first edge only opens an interval; there is no sample yet.
               if (filt_edge) begin
                  state_q <= ST_MEASURE;
                  flags_q <= FLAGS_NONE;
               end
            end
            ST_MEASURE: begin
               if (filt_edge) begin
                  half_period_q  <= cnt_q;
                  sample_valid_q <= 1'b1;
                  nsamp_q        <= nsamp_q + 1'b1;
                  if (nsamp_q == '1) begin
                     avg_pend_q <= 1'b1;
                  end
               end else if (timeout_hit) begin
                  // half_period and half_period_avg keep their last values.
                  state_q <= ST_SILENT;
                  flags_q <= FLAGS_SILENT;
                  nsamp_q <= '0;
               end
            end
            default: state_q <= ST_SILENT;
         endcase
      end
   end

   assign half_period     = half_period_q;
   assign sample_valid    = sample_valid_q;
   assign half_period_avg = avg_q;
   assign avg_valid       = avg_valid_q;
   assign tone_a4         = flags_q.a4;
   assign tone_a5         = flags_q.a5;
   assign tone_other      = flags_q.other;
   assign silent          = flags_q.silent;
   assign led             = flags_q;

endmodule

// File: tb/tb_tone_detector.sv
// -----------------------------------------------------------------------------
// tb_tone_detector
//   Directed bench for tone_detector. Tone constants and the timeout are
//   scaled down (A4=284, A5=142, TOL=8, TIMEOUT=2500, CNT_W=12) so every
//   scenario stays short; the relationships between them mirror the defaults.
// -----------------------------------------------------------------------------
module tb_tone_detector;

   localparam int unsigned CNT_W   = 12;
   localparam int unsigned A4      = 284;
   localparam int unsigned A5      = 142;
   localparam int unsigned TOL     = 8;
   localparam int unsigned AVG_L2  = 3;
   localparam int unsigned GLITCH  = 4;
   localparam int unsigned TIMEOUT = 2500;

   logic             clk_25mhz = 1'b0;
   logic             resetn;
   logic             audio_in;
   logic [CNT_W-1:0] half_period;
   logic             sample_valid;
   logic [CNT_W-1:0] half_period_avg;
   logic             avg_valid;
   logic             tone_a4;
   logic             tone_a5;
   logic             tone_other;
   logic             silent;
   logic [3:0]       led;

   tone_detector #(
      .CNT_W          (CNT_W),
      .TONE_A4_HALF   (A4),
      .TONE_A5_HALF   (A5),
      .TOL            (TOL),
      .AVG_LOG2       (AVG_L2),
      .GLITCH_CYCLES  (GLITCH),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_25mhz       (clk_25mhz),
      .resetn          (resetn),
      .audio_in        (audio_in),
      .half_period     (half_period),
      .sample_valid    (sample_valid),
      .half_period_avg (half_period_avg),
      .avg_valid       (avg_valid),
      .tone_a4         (tone_a4),
      .tone_a5         (tone_a5),
      .tone_other      (tone_other),
      .silent          (silent),
      .led             (led)
   );

   always #20 clk_25mhz = ~clk_25mhz;

   int n_cmp = 0;
   int n_err = 0;

   // Event log, sampled on the falling edge.
   int cyc = 0;
   int samp_q[$];
   int samp_cyc_q[$];
   int avg_q[$];
   int avg_cyc_q[$];
   int onehot_err = 0;
   int silent_rise = 0;
   logic silent_prev = 1'b1;

   always @(negedge clk_25mhz) begin
      cyc++;
      if (sample_valid) begin
         samp_q.push_back(int'(half_period));
         samp_cyc_q.push_back(cyc);
      end
      if (avg_valid) begin
         avg_q.push_back(int'(half_period_avg));
         avg_cyc_q.push_back(cyc);
      end
      if ($countones(led) > 1) onehot_err++;
      if (silent && !silent_prev) silent_rise++;
      silent_prev = silent;
   end

   task automatic do_reset();
      resetn   = 1'b0;
      audio_in = 1'b0;
      repeat (3) @(posedge clk_25mhz);
      #1 resetn = 1'b1;
      @(posedge clk_25mhz);
      #1;
   endtask

   // Toggle the pin n times, holding each level for 'half' cycles.
   task automatic drive(input int half, input int n);
      for (int i = 0; i < n; i++) begin
         audio_in = ~audio_in;
         repeat (half) @(posedge clk_25mhz);
         #1;
      end
   endtask

   task automatic test_reset();
      int sb, ab;
      sb = samp_q.size();
      ab = avg_q.size();
      resetn   = 1'b0;
      audio_in = 1'b0;
      for (int i = 0; i < 10; i++) begin
         repeat (2) @(posedge clk_25mhz);
         #1 audio_in = ~audio_in;
      end
      n_cmp++; if (led !== 4'b1000) begin n_err++; $display("FAIL reset_led: got %b expected 1000", led); end
      n_cmp++; if (silent !== 1'b1) begin n_err++; $display("FAIL reset_silent: got %b expected 1", silent); end
      n_cmp++; if ({tone_a4, tone_a5, tone_other} !== 3'b000) begin n_err++; $display("FAIL reset_tones: got %b expected 000", {tone_a4, tone_a5, tone_other}); end
      n_cmp++; if (half_period !== '0 || half_period_avg !== '0) begin n_err++; $display("FAIL reset_values: got hp=%0d avg=%0d expected 0/0", half_period, half_period_avg); end
      n_cmp++; if (samp_q.size() != sb || avg_q.size() != ab) begin n_err++; $display("FAIL reset_pulses: got %0d samples %0d avgs expected 0/0", samp_q.size() - sb, avg_q.size() - ab); end
   endtask

   task automatic test_glitch();
      int sb;
      do_reset();
      sb = samp_q.size();
      audio_in = 1'b1;
      repeat (3) @(posedge clk_25mhz);
      #1 audio_in = 1'b0;
      repeat (20) @(posedge clk_25mhz);
      #1;
      n_cmp++; if (silent !== 1'b1) begin n_err++; $display("FAIL glitch3_silent: got %b expected 1", silent); end
      // 4-cycle pulse: rising edge accepted 6 cycles after the pin change,
      // silent drops the cycle after.
      audio_in = 1'b1;
      repeat (4) @(posedge clk_25mhz);
      #1 audio_in = 1'b0;
      repeat (2) @(posedge clk_25mhz);
      #1;
      n_cmp++; if (silent !== 1'b1) begin n_err++; $display("FAIL glitch4_latency_early: got silent=%b expected 1", silent); end
      @(posedge clk_25mhz);
      #1;
      n_cmp++; if (silent !== 1'b0) begin n_err++; $display("FAIL glitch4_latency: got silent=%b expected 0", silent); end
      repeat (10) @(posedge clk_25mhz);
      #1;
      n_cmp++; if (samp_q.size() != sb + 1) begin n_err++; $display("FAIL glitch4_nsamp: got %0d expected 1", samp_q.size() - sb); end
      else begin
         n_cmp++; if (samp_q[sb] != 4) begin n_err++; $display("FAIL glitch4_width: got %0d expected 4", samp_q[sb]); end
      end
      n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL glitch4_led: got %b expected 0000", led); end
   endtask

   task automatic test_a4();
      int sb, ab, bad;
      do_reset();
      sb = samp_q.size();
      ab = avg_q.size();
      drive(A4, 2);
      n_cmp++; if (led !== 4'b0000) begin n_err++; $display("FAIL a4_pre_avg_led: got %b expected 0000", led); end
      drive(A4, 7);
      n_cmp++; if (samp_q.size() != sb + 8) begin n_err++; $display("FAIL a4_nsamp: got %0d expected 8", samp_q.size() - sb); end
      bad = 0;
      for (int i = sb; i < samp_q.size(); i++) if (samp_q[i] != A4) bad++;
      n_cmp++; if (bad != 0) begin n_err++; $display("FAIL a4_samples: got %0d samples not equal to 284, expected 0", bad); end
      n_cmp++; if (avg_q.size() != ab + 1) begin n_err++; $display("FAIL a4_navg: got %0d expected 1", avg_q.size() - ab); end
      else begin
         n_cmp++; if (avg_q[ab] != A4) begin n_err++; $display("FAIL a4_avg: got %0d expected 284", avg_q[ab]); end
         n_cmp++; if (avg_cyc_q[ab] != samp_cyc_q[samp_cyc_q.size() - 1] + 1) begin n_err++; $display("FAIL a4_avg_timing: got cycle %0d expected %0d", avg_cyc_q[ab], samp_cyc_q[samp_cyc_q.size() - 1] + 1); end
      end
      n_cmp++; if (tone_a4 !== 1'b1 || led !== 4'b0001) begin n_err++; $display("FAIL a4_flags: got a4=%b led=%b expected 1/0001", tone_a4, led); end
      n_cmp++; if (half_period !== CNT_W'(A4) || half_period_avg !== CNT_W'(A4)) begin n_err++; $display("FAIL a4_outputs: got hp=%0d avg=%0d expected 284/284", half_period, half_period_avg); end
   endtask

   typedef struct {
      int         half;
      logic [3:0] exp_led;
   } win_t;

   task automatic test_classify();
      win_t tbl[6];
      int ab;
      tbl[0] = '{142, 4'b0010};   // A5 exact
      tbl[1] = '{150, 4'b0010};   // A5 + TOL, inclusive
      tbl[2] = '{152, 4'b0100};   // A5 + TOL + 2
      tbl[3] = '{134, 4'b0010};   // A5 - TOL, inclusive
      tbl[4] = '{292, 4'b0001};   // A4 + TOL, inclusive
      tbl[5] = '{293, 4'b0100};   // A4 + TOL + 1
      foreach (tbl[k]) begin
         do_reset();
         ab = avg_q.size();
         drive(tbl[k].half, 9);
         n_cmp++; if (avg_q.size() != ab + 1) begin n_err++; $display("FAIL cls_navg[%0d]: got %0d expected 1", tbl[k].half, avg_q.size() - ab); end
         else begin
            n_cmp++; if (avg_q[ab] != tbl[k].half) begin n_err++; $display("FAIL cls_avg[%0d]: got %0d expected %0d", tbl[k].half, avg_q[ab], tbl[k].half); end
         end
         n_cmp++; if (led !== tbl[k].exp_led) begin n_err++; $display("FAIL cls_led[%0d]: got %b expected %b", tbl[k].half, led, tbl[k].exp_led); end
      end
      // Seven samples of 151 and one of 150: sum 1207, truncated mean 150.
      do_reset();
      ab = avg_q.size();
      drive(151, 7);
      drive(150, 2);
      n_cmp++; if (avg_q.size() != ab + 1) begin n_err++; $display("FAIL trunc_navg: got %0d expected 1", avg_q.size() - ab); end
      else begin
         n_cmp++; if (avg_q[ab] != 150) begin n_err++; $display("FAIL trunc_avg: got %0d expected 150", avg_q[ab]); end
      end
      n_cmp++; if (led !== 4'b0010) begin n_err++; $display("FAIL trunc_led: got %b expected 0010", led); end
   endtask

   task automatic test_timeout();
      do_reset();
      drive(A4, 9);
      n_cmp++; if (tone_a4 !== 1'b1) begin n_err++; $display("FAIL to_pre_a4: got %b expected 1", tone_a4); end
      // Last pin toggle was A4 cycles ago; silent rises TIMEOUT+7 cycles after it.
      repeat (TIMEOUT + 6 - A4) @(posedge clk_25mhz);
      #1;
      n_cmp++; if (silent !== 1'b0 || tone_a4 !== 1'b1) begin n_err++; $display("FAIL to_early: got silent=%b a4=%b expected 0/1", silent, tone_a4); end
      @(posedge clk_25mhz);
      #1;
      n_cmp++; if (silent !== 1'b1 || led !== 4'b1000) begin n_err++; $display("FAIL to_fire: got silent=%b led=%b expected 1/1000", silent, led); end
      n_cmp++; if (half_period !== CNT_W'(A4) || half_period_avg !== CNT_W'(A4)) begin n_err++; $display("FAIL to_hold: got hp=%0d avg=%0d expected 284/284", half_period, half_period_avg); end
   endtask

   task automatic test_edge_on_timeout();
      int sb, rb;
      do_reset();
      sb = samp_q.size();
      drive(TIMEOUT, 1);
      drive(TIMEOUT + 1, 1);
      n_cmp++; if (samp_q.size() != sb + 1) begin n_err++; $display("FAIL eot_nsamp: got %0d expected 1", samp_q.size() - sb); end
      else begin
         n_cmp++; if (samp_q[sb] != TIMEOUT) begin n_err++; $display("FAIL eot_sample: got %0d expected 2500", samp_q[sb]); end
      end
      n_cmp++; if (silent !== 1'b0) begin n_err++; $display("FAIL eot_measure: got silent=%b expected 0", silent); end
      // One cycle too long: timeout first, then the edge restarts without a sample.
      rb = silent_rise;
      drive(10, 1);
      n_cmp++; if (silent_rise != rb + 1) begin n_err++; $display("FAIL late_timeout: got %0d silent rises expected 1", silent_rise - rb); end
      n_cmp++; if (samp_q.size() != sb + 1) begin n_err++; $display("FAIL late_nsamp: got %0d expected 1", samp_q.size() - sb); end
      n_cmp++; if (silent !== 1'b0) begin n_err++; $display("FAIL late_remeasure: got silent=%b expected 0", silent); end
   endtask

   task automatic test_reset_mid();
      int sb, ab;
      do_reset();
      sb = samp_q.size();
      ab = avg_q.size();
      drive(A4, 6);
      n_cmp++; if (samp_q.size() != sb + 5) begin n_err++; $display("FAIL mid_nsamp: got %0d expected 5", samp_q.size() - sb); end
      resetn = 1'b0;
      #1;
      n_cmp++; if (silent !== 1'b1 || led !== 4'b1000 || half_period !== '0) begin n_err++; $display("FAIL mid_reset: got silent=%b led=%b hp=%0d expected 1/1000/0", silent, led, half_period); end
      do_reset();
      n_cmp++; if (avg_q.size() != ab) begin n_err++; $display("FAIL mid_partial: got %0d averages expected 0", avg_q.size() - ab); end
      drive(A4, 8);
      n_cmp++; if (avg_q.size() != ab) begin n_err++; $display("FAIL mid_seven: got %0d averages expected 0", avg_q.size() - ab); end
      drive(A4, 1);
      n_cmp++; if (avg_q.size() != ab + 1) begin n_err++; $display("FAIL mid_eight: got %0d averages expected 1", avg_q.size() - ab); end
      else begin
         n_cmp++; if (avg_q[ab] != A4) begin n_err++; $display("FAIL mid_avg: got %0d expected 284", avg_q[ab]); end
      end
      n_cmp++; if (led !== 4'b0001) begin n_err++; $display("FAIL mid_led: got %b expected 0001", led); end
   endtask

   initial begin
      resetn   = 1'b0;
      audio_in = 1'b0;
      test_reset();
      test_glitch();
      test_a4();
      test_classify();
      test_timeout();
      test_edge_on_timeout();
      test_reset_mid();
      n_cmp++; if (onehot_err != 0) begin n_err++; $display("FAIL flags_onehot: got %0d cycles with >1 flag expected 0", onehot_err); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
